nes_pad_reader: RTL and testbench

Serial NES gamepad front end for the game top level. It generates the controller latch and clock and shifts in the eight active-low button bits once per poll request. It delivers registered button levels plus one-cycle pressed/released pulses to the input controller and player logic. It is polled from the frame-end timing signal, so button state is refreshed once per video frame.

---
 rtl/nes_pad_reader.sv | 157 +++++++++++++++
 tb/tb_nes_pad_reader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/nes_pad_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nes_pad_reader: NES pad latch/clock generator and 8-bit serial receiver     |
// | with registered button levels and pressed/released/valid pulses.            |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module nes_pad_reader #(
  parameter int LATCH_CYCLES = 300,
  parameter int HALF_CYCLES  = 150
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons,
  output logic [7:0] pressed,
  output logic [7:0] released,
  output logic       valid,
  output logic       busy,
  output logic       present
);

  localparam int CNT_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_GAP    = 3'd2,
    S_CLK_HI = 3'd3,
    S_CLK_LO = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] phase;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic [7:0]       new_buttons;
  logic             new_present;

  // An all-ones byte means the data line never went high: no pad attached.
  always_comb begin
    new_buttons = shreg;
    new_present = 1'b1;
    if (shreg == 8'hFF) begin
      new_buttons = 8'h00;
      new_present = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= nes_data;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      phase     <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      nes_latch <= 1'b0;
      nes_clk   <= 1'b0;
      buttons   <= 8'h00;
      pressed   <= 8'h00;
      released  <= 8'h00;
      valid     <= 1'b0;
      busy      <= 1'b0;
      present   <= 1'b0;
    end else begin
      pressed  <= 8'h00;
      released <= 8'h00;
      valid    <= 1'b0;
      case (state)
        S_IDLE: begin
          busy    <= trigger;
          phase   <= '0;
          bit_idx <= 3'd0;
          if (trigger) begin
            nes_latch <= 1'b1;
            state     <= S_LATCH;
          end
        end
        S_LATCH: begin
          if (phase == LATCH_LAST) begin
            phase     <= '0;
            nes_latch <= 1'b0;
            state     <= S_GAP;
          end else begin
            phase <= phase + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (phase == HALF_LAST) begin
            phase   <= '0;
            shreg   <= {~sync2, shreg[7:1]};
            bit_idx <= 3'd1;
            nes_clk <= 1'b1;
            state   <= S_CLK_HI;
          end else begin
            phase <= phase + CNT_W'(1);
          end
        end
        S_CLK_HI: begin
          if (phase == HALF_LAST) begin
            phase   <= '0;
            nes_clk <= 1'b0;
            state   <= S_CLK_LO;
          end else begin
            phase <= phase + CNT_W'(1);
          end
        end
        S_CLK_LO: begin
          if (phase == HALF_LAST) begin
            phase <= '0;
            shreg <= {~sync2, shreg[7:1]};
            // The last bit needs no further clock pulse.
            if (bit_idx == 3'd7) begin
              state <= S_DONE;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              nes_clk <= 1'b1;
              state   <= S_CLK_HI;
            end
          end else begin
            phase <= phase + CNT_W'(1);
          end
        end
        S_DONE: begin
          buttons  <= new_buttons;
          pressed  <= new_buttons & ~buttons;
          released <= ~new_buttons & buttons;
          present  <= new_present;
          valid    <= 1'b1;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nes_pad_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_nes_pad_reader: self-checking bench with a serial pad model.             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_nes_pad_reader;

  localparam int LATCH_CYCLES = 8;
  localparam int HALF_CYCLES  = 4;
  localparam int POLL_LAT     = LATCH_CYCLES + 15 * HALF_CYCLES + 1;

  logic       clk;
  logic       reset;
  logic       trigger;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_clk;
  logic [7:0] buttons;
  logic [7:0] pressed;
  logic [7:0] released;
  logic       valid;
  logic       busy;
  logic       present;

  int n_checks = 0;
  int n_fail   = 0;

  nes_pad_reader #(
    .LATCH_CYCLES(LATCH_CYCLES),
    .HALF_CYCLES (HALF_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .trigger  (trigger),
    .nes_data (nes_data),
    .nes_latch(nes_latch),
    .nes_clk  (nes_clk),
    .buttons  (buttons),
    .pressed  (pressed),
    .released (released),
    .valid    (valid),
    .busy     (busy),
    .present  (present)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pad: serial bit i of the stream is presented after the latch and i clock rises.
  logic [7:0] pad_stream = 8'hFF;
  bit         pad_stuck  = 1'b0;
  int         pad_idx    = 0;
  always @(posedge nes_latch) pad_idx = 0;
  always @(posedge nes_clk) pad_idx = pad_idx + 1;
  always_comb begin
    nes_data = 1'b0;
    if (!pad_stuck && pad_idx < 8) nes_data = pad_stream[pad_idx[2:0]];
  end

  logic [7:0] m_buttons = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decode the serial stream bit by bit, then apply the edge rules.
  function automatic void model_step(input logic [7:0] stream, input bit stuck,
                                     output logic [7:0] eb, output logic [7:0] ep,
                                     output logic [7:0] er, output logic epres);
    logic [7:0] held;
    int n_held = 0;
    for (int i = 0; i < 8; i++) begin
      held[i] = stuck ? 1'b1 : (stream[i] == 1'b0);
      if (held[i]) n_held++;
    end
    if (n_held == 8) begin
      held  = 8'h00;
      epres = 1'b0;
    end else begin
      epres = 1'b1;
    end
    ep = held & ~m_buttons;
    er = m_buttons & ~held;
    eb = held;
    m_buttons = held;
  endfunction

  task automatic run_poll(input string tag, input logic [7:0] stream, input bit stuck,
                          input logic [7:0] eb, input logic [7:0] ep,
                          input logic [7:0] er, input logic epres);
    int latch_cnt;
    int nclk_cnt;
    int valid_at;
    logic prev_clk;
    pad_stream = stream;
    pad_stuck  = stuck;
    @(negedge clk); trigger = 1'b1;
    @(negedge clk); trigger = 1'b0;
    check({tag, "_latch_rise"}, nes_latch, 1);
    check({tag, "_busy_rise"}, busy, 1);
    latch_cnt = 1;
    nclk_cnt  = 0;
    prev_clk  = nes_clk;
    valid_at  = -1;
    for (int n = 1; n <= 200 && valid_at < 0; n++) begin
      @(negedge clk);
      if (nes_latch) latch_cnt++;
      if (nes_clk && !prev_clk) nclk_cnt++;
      prev_clk = nes_clk;
      if (valid) valid_at = n;
    end
    check({tag, "_valid_time"}, valid_at, POLL_LAT);
    check({tag, "_latch_len"}, latch_cnt, LATCH_CYCLES);
    check({tag, "_nclk_pulses"}, nclk_cnt, 7);
    check({tag, "_buttons"}, buttons, eb);
    check({tag, "_pressed"}, pressed, ep);
    check({tag, "_released"}, released, er);
    check({tag, "_present"}, present, epres);
    @(negedge clk);
    check({tag, "_valid_pulse"}, valid, 0);
    check({tag, "_busy_fall"}, busy, 0);
    check({tag, "_pulses_clear"}, {pressed, released}, 16'h0);
  endtask

  typedef struct {
    logic [7:0] stream;
    bit         stuck;
    logic [7:0] exp_buttons;
    logic [7:0] exp_pressed;
    logic [7:0] exp_released;
    logic       exp_present;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   vcount;
    int   vtimes[2];
    logic [7:0] eb, ep, er;
    logic epres;
    logic [7:0] rstream;
    bit   rstuck;

    vecs[0] = '{8'h7E, 1'b0, 8'h81, 8'h81, 8'h00, 1'b1};  // A + Right
    vecs[1] = '{8'hF7, 1'b0, 8'h08, 8'h08, 8'h81, 1'b1};  // Start only
    vecs[2] = '{8'hF7, 1'b0, 8'h08, 8'h00, 8'h00, 1'b1};  // unchanged
    vecs[3] = '{8'hFF, 1'b1, 8'h00, 8'h00, 8'h08, 1'b0};  // stuck low
    vecs[4] = '{8'hFF, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1};  // idle high

    reset   = 1'b1;
    trigger = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {nes_latch, nes_clk, valid, busy, present}, 5'b0);
    check("reset_vectors", {buttons, pressed, released}, 24'h0);
    reset = 1'b0;
    @(negedge clk);

    // Abort a poll during the latch pulse.
    @(negedge clk); trigger = 1'b1;
    @(negedge clk); trigger = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_in_latch", nes_latch, 1);
    reset = 1'b1;
    #1;
    check("abort_outputs", {nes_latch, nes_clk, busy, valid}, 4'b0);
    @(negedge clk); reset = 1'b0;
    vcount = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    check("abort_no_valid", vcount, 0);

    run_poll("post_reset", 8'hFF, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);

    for (int i = 0; i < 5; i++) begin
      run_poll($sformatf("vec%0d", i), vecs[i].stream, vecs[i].stuck, vecs[i].exp_buttons,
               vecs[i].exp_pressed, vecs[i].exp_released, vecs[i].exp_present);
    end
    m_buttons = 8'h00;

    // Triggers during a poll must be dropped, not queued.
    pad_stream = 8'hFF;
    pad_stuck  = 1'b0;
    @(negedge clk); trigger = 1'b1;
    @(negedge clk); trigger = 1'b0;
    vcount = 0;
    for (int n = 1; n <= 180; n++) begin
      @(negedge clk);
      trigger = (n == 10 || n == 40);
      if (valid) vcount++;
    end
    trigger = 1'b0;
    check("busy_trigger_single_valid", vcount, 1);

    // Held trigger runs polls back to back.
    @(negedge clk); trigger = 1'b1;
    vcount = 0;
    for (int n = 1; n <= 300 && vcount < 2; n++) begin
      @(negedge clk);
      if (valid) begin
        vtimes[vcount] = n;
        vcount++;
      end
    end
    trigger = 1'b0;
    check("held_two_valids", vcount, 2);
    if (vcount == 2) check("held_valid_spacing", vtimes[1] - vtimes[0], POLL_LAT + 1);
    vcount = 0;
    for (int n = 0; n < 200 && busy; n++) @(negedge clk);
    check("held_returns_idle", busy, 0);

    for (int i = 0; i < 16; i++) begin
      rstream = 8'($urandom);
      rstuck  = ($urandom_range(0, 5) == 0);
      model_step(rstream, rstuck, eb, ep, er, epres);
      run_poll($sformatf("rand%0d", i), rstream, rstuck, eb, ep, er, epres);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
